multiply_accumulate: RTL
========================

# multiply_accumulate

Streaming signed/unsigned multiply-accumulate unit for the datapath: accepts operand pairs over a strobe/ready handshake, multiplies them in a registered pipeline and sums products across a vector delimited by a last flag. One result per vector is presented on the master port, saturated or truncated to 2·W bits with an overflow flag. It is the vector-capable successor to the single-product multiplier, used for dot products in the neuron/weight path.

## Interface
- W, default 8: operand width in bits.
- G, default 8: accumulator guard bits; accumulator width A = 2·W+G.
- SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
- SAT, default 1: 1 = clamp result to 2·W range, 0 = truncate to low 2·W bits.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_stb  input  1  input beat valid.
- s_dat  input  2·W  operands: arg0 = s_dat[W-1:0], arg1 = s_dat[2W-1:W].
- s_lst  input  1  beat is last of vector; qualified by s_stb.
- s_rdy  output  1  input beat accepted when s_stb & s_rdy.
- m_rdy  input  1  downstream ready.
- m_stb  output  1  result valid.
- m_dat  output  2·W  result.
- m_ovf  output  1  result clamped (SAT=1) or truncated with loss (SAT=0).

## Operation
- Global enable en = ~m_stb | m_rdy; s_rdy = en (combinational). When en=0 the whole pipeline holds; no internal state changes.
- Stage 0 (on en): capture arg0, arg1, s_lst; v0 <= s_stb.
- Stage 1 (on en): p <= arg0·arg1 (2·W bits, signedness per SIGNED); v1 <= v0; l1 <= l0.
- Stage 2 (on en, when v1): sum = (first ? 0 : acc) + ext(p), ext = sign- or zero-extension to A bits; acc wraps mod 2^A (G sized by user to avoid it).
  - l1=0: acc <= sum; first <= 0.
  - l1=1: m_dat <= fit(sum); m_ovf <= overflow(sum); m_stb <= 1; first <= 1 (acc discarded).
- When en and no l1 result produced this cycle and m_stb & m_rdy: m_stb <= 0 (result consumed).
- fit, SIGNED=1: range [-2^(2W-1), 2^(2W-1)-1]; SIGNED=0: [0, 2^(2W)-1]. SAT=1: out-of-range clamps to nearest bound, m_ovf=1. SAT=0: low 2·W bits, m_ovf=1 iff discarded upper bits are not a pure extension of the kept result.
- Result and m_ovf held stable while m_stb & ~m_rdy.
- Vector length unbounded; a vector of one beat is legal.
- Beats with s_stb=0 insert bubbles; bubbles do not affect acc or first.

## Timing
- Reset (rst_n low, immediate): m_stb=0, m_dat=0, m_ovf=0, v0=v1=0, acc=0, first=1. s_rdy=1 during and after reset.
- Reset mid-vector discards all in-flight beats and partial sum; next accepted beat starts a new vector.
- Latency: last beat accepted on edge E0 → m_stb high after edge E0+2 (when en held high).
- Throughput: one beat per cycle while en=1; back-to-back single-beat vectors yield one result per cycle when m_rdy=1.
- Simultaneous consume and new result (m_stb & m_rdy & v1 & l1): m_stb stays 1, m_dat updates, no gap.
- m_stb & ~m_rdy stalls input even if pending beats are not last (decided simplicity/throughput trade).

## Test plan
- W=8,G=8,SIGNED=1,SAT=1: single beat arg0=3, arg1=-4, lst=1 → m_dat=0xFFF4, m_ovf=0, m_stb 2 cycles after acceptance edge.
- Vector (1,2),(3,4),(5,6) lst on third, then (2,2) lst → results 44 then 4 (accumulator cleared between vectors), with and without interleaved bubbles.
- Four beats (-128,-128), lst on fourth → sum 65536 → m_dat=0x7FFF, m_ovf=1; same with SAT=0 → m_dat=0x0000, m_ovf=1.
- Back-to-back single-beat vectors with m_rdy random: s_rdy=0 exactly when m_stb & ~m_rdy, m_dat stable while stalled, no result lost or duplicated vs. reference model.
- rst_n pulsed low after two beats of a vector → m_stb=0 immediately; subsequent vector (7,7) lst → 49 only.
- SIGNED=0 instance: (255,255) lst → 0xFE01, m_ovf=0; two beats (255,255) lst on second → 0xFFFF, m_ovf=1.

Source files
------------

// File: rtl/multiply_accumulate.sv
// Streaming multiply-accumulate: registered operand capture, registered product,
// and per-vector accumulation with a saturating or truncating 2*W result port.
module multiply_accumulate #(
    parameter int W      = 8,
    parameter int G      = 8,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_stb,
    input  logic [2*W-1:0] s_dat,
    input  logic           s_lst,
    output logic           s_rdy,
    input  logic           m_rdy,
    output logic           m_stb,
    output logic [2*W-1:0] m_dat,
    output logic           m_ovf
);
    localparam int P = 2 * W;
    localparam int A = P + G;

    logic         en;

    logic [W-1:0] a0_q, a0_d;
    logic [W-1:0] a1_q, a1_d;
    logic         l0_q, l0_d;
    logic         v0_q, v0_d;

    logic [P-1:0] p_q, p_d;
    logic         l1_q, l1_d;
    logic         v1_q, v1_d;

    logic [A-1:0] acc_q, acc_d;
    logic         first_q, first_d;

    logic         m_stb_q, m_stb_d;
    logic [P-1:0] m_dat_q, m_dat_d;
    logic         m_ovf_q, m_ovf_d;

    logic [P-1:0]        a0_ext;
    logic [P-1:0]        a1_ext;
    logic [A-1:0]        p_ext;
    logic [A-1:0]        sum;
    logic signed [A-1:0] sum_hi;
    logic                in_range;
    logic [P-1:0]        fit_dat;

    // A held result freezes every stage, so upstream sees back-pressure at once.
    assign en    = ~m_stb_q | m_rdy;
    assign s_rdy = en;
    assign m_stb = m_stb_q;
    assign m_dat = m_dat_q;
    assign m_ovf = m_ovf_q;

    always_comb begin
        if (SIGNED) begin
            a0_ext = {{W{a0_q[W-1]}}, a0_q};
            a1_ext = {{W{a1_q[W-1]}}, a1_q};
            p_ext  = A'($signed(p_q));
        end else begin
            a0_ext = {{W{1'b0}}, a0_q};
            a1_ext = {{W{1'b0}}, a1_q};
            p_ext  = A'(p_q);
        end
    end

    // Bits above the kept result must be a pure sign (or zero) extension for it to fit.
    always_comb begin
        sum = (first_q ? {A{1'b0}} : acc_q) + p_ext;
        if (SIGNED) begin
            sum_hi   = $signed(sum) >>> (P - 1);
            in_range = (sum_hi == '0) || (sum_hi == '1);
        end else begin
            sum_hi   = $signed(sum >> P);
            in_range = (sum_hi == '0);
        end

        if (in_range || !SAT) begin
            fit_dat = sum[P-1:0];
        end else if (SIGNED) begin
            fit_dat = sum[A-1] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
        end else begin
            fit_dat = '1;
        end
    end

    always_comb begin
        a0_d    = a0_q;
        a1_d    = a1_q;
        l0_d    = l0_q;
        v0_d    = v0_q;
        p_d     = p_q;
        l1_d    = l1_q;
        v1_d    = v1_q;
        acc_d   = acc_q;
        first_d = first_q;
        m_stb_d = m_stb_q;
        m_dat_d = m_dat_q;
        m_ovf_d = m_ovf_q;

        if (en) begin
            a0_d = s_dat[W-1:0];
            a1_d = s_dat[P-1:W];
            l0_d = s_lst;
            v0_d = s_stb;

            p_d  = a0_ext * a1_ext;
            l1_d = l0_q;
            v1_d = v0_q;

            if (v1_q && l1_q) begin
                m_stb_d = 1'b1;
                m_dat_d = fit_dat;
                m_ovf_d = ~in_range;
                first_d = 1'b1;
            end else begin
                if (v1_q) begin
                    acc_d   = sum;
                    first_d = 1'b0;
                end
                if (m_stb_q && m_rdy) begin
                    m_stb_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_q    <= '0;
            a1_q    <= '0;
            l0_q    <= 1'b0;
            v0_q    <= 1'b0;
            p_q     <= '0;
            l1_q    <= 1'b0;
            v1_q    <= 1'b0;
            acc_q   <= '0;
            first_q <= 1'b1;
            m_stb_q <= 1'b0;
            m_dat_q <= '0;
            m_ovf_q <= 1'b0;
        end else begin
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            l0_q    <= l0_d;
            v0_q    <= v0_d;
            p_q     <= p_d;
            l1_q    <= l1_d;
            v1_q    <= v1_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            m_stb_q <= m_stb_d;
            m_dat_q <= m_dat_d;
            m_ovf_q <= m_ovf_d;
        end
    end

endmodule
